// File: rtl/pll_lock_reset_seq.sv
// Purpose : synchronise PLL lock, qualify it for a stable interval, then release the
//           pixel-domain reset aligned to a divide-by-DIV pixel clock enable.
// Latency : pll_lock -> lock_s 2 cycles; lock loss -> sys_rst high on the 3rd clk edge.
// Backpr. : none; free-running sequencer with no flow control.
module pll_lock_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int DIV                = 5,
  parameter int LOSS_W             = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pll_lock,
  input  logic                    clear_cnt,
  output logic                    pix_ce,
  output logic [$clog2(DIV)-1:0]  pix_phase,
  output logic                    sys_rst,
  output logic                    ready,
  output logic [LOSS_W-1:0]       lock_loss_cnt
);

  localparam int PH_W  = $clog2(DIV);
  localparam int CNT_W = $clog2(LOCK_STABLE_CYCLES) + 1;

  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX = {LOSS_W{1'b1}};

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_ARM       = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Synchroniser chain; r_lock_s is the only view of the PLL lock the rest of the block uses.
  logic              r_sync1;
  logic              r_lock_s;

  // Pixel phase generator.
  logic [PH_W-1:0]   r_phase;
  logic [PH_W-1:0]   w_phase_nxt;
  logic              r_pix_ce;

  // Sequencer state and stability counter.
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_stab_cnt;
  logic [CNT_W-1:0]  w_stab_cnt_nxt;

  // Lock-loss debug counter.
  logic [LOSS_W-1:0] r_loss_cnt;
  logic              w_lock_fall;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_lock;
      r_lock_s <= r_sync1;
    end
  end

  // lock_s is about to drop on this edge: it is 1 now and the next value entering it is 0.
  assign w_lock_fall = r_lock_s & ~r_sync1;

  // Phase advance with wrap at DIV-1; reset value DIV-1 makes the first post-reset cycle phase 0.
  always_comb begin
    w_phase_nxt = r_phase + PH_W'(1);
    if (r_phase == PH_LAST) begin
      w_phase_nxt = '0;
    end
  end

  // Free-running phase counter and registered pixel enable (high exactly when phase is 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= PH_LAST;
      r_pix_ce <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_pix_ce <= (w_phase_nxt == '0);
    end
  end

  // Sequencer state and stability counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_WAIT_LOCK;
      r_stab_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_cnt_nxt;
    end
  end

  // Next-state logic: any loss of lock_s returns to WAIT_LOCK and forces a full recount;
  // ARM waits for the last phase so that RUN always begins on a pixel-enable cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_stab_cnt_nxt = '0;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_state_nxt = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_stab_cnt == CNT_LAST) begin
          w_state_nxt = ST_ARM;
        end else begin
          w_stab_cnt_nxt = r_stab_cnt + CNT_W'(1);
        end
      end
      ST_ARM: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_phase == PH_LAST) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
      end
    endcase
  end

  // Saturating lock-loss counter; a clear coincident with a drop keeps that drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loss_cnt <= '0;
    end else if (clear_cnt) begin
      r_loss_cnt <= w_lock_fall ? LOSS_W'(1) : '0;
    end else if (w_lock_fall && (r_loss_cnt != LOSS_MAX)) begin
      r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
    end
  end

  assign pix_ce        = r_pix_ce;
  assign pix_phase     = r_phase;
  assign sys_rst       = (r_state != ST_RUN);
  assign ready         = (r_state == ST_RUN);
  assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Purpose : self-checking bench for pll_lock_reset_seq (DIV=5, LOCK_STABLE_CYCLES=16, LOSS_W=8).
// Latency : reference model advances once per clk edge, outputs compared 1 time unit later.
// Backpr. : n/a.
module tb_pll_lock_reset_seq;

  localparam int N  = 16;
  localparam int DV = 5;
  localparam int LW = 8;
  localparam int PW = $clog2(DV);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pll_lock = 1'b0;
  logic          clear_cnt = 1'b0;
  logic          pix_ce;
  logic [PW-1:0] pix_phase;
  logic          sys_rst;
  logic          ready;
  logic [LW-1:0] lock_loss_cnt;

  int n_total = 0;
  int n_bad   = 0;

  pll_lock_reset_seq #(
    .LOCK_STABLE_CYCLES(N),
    .DIV               (DV),
    .LOSS_W            (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .clear_cnt    (clear_cnt),
    .pix_ce       (pix_ce),
    .pix_phase    (pix_phase),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: k = edges since reset release; lock_s(k) = pll_lock sampled at edge k-1;
  // RUN at k iff lock_s has been 1 from streak start t0 through k-1 and the first multiple of DIV
  // at or after t0+N+1 (an ARM cycle with phase DIV-1) is no later than k-1.
  int   m_k, m_ones, m_cnt, m_phase;
  logic m_p_prev, m_ls, m_run;

  task automatic model_reset();
    m_k = 0; m_ones = 0; m_cnt = 0; m_phase = DV - 1;
    m_p_prev = 1'b0; m_ls = 1'b0; m_run = 1'b0;
  endtask

  task automatic model_edge(input logic p, input logic c);
    logic new_ls, fall;
    int t0, lo, a;
    m_k++;
    new_ls   = m_p_prev;
    m_p_prev = p;
    fall     = m_ls && !new_ls;
    if (c) m_cnt = fall ? 1 : 0;
    else if (fall && m_cnt < (1 << LW) - 1) m_cnt++;
    if (m_ones > 0) begin
      t0    = m_k - m_ones;
      lo    = t0 + N + 1;
      a     = ((lo + DV - 1) / DV) * DV;
      m_run = (a <= m_k - 1);
    end else begin
      m_run = 1'b0;
    end
    m_ones  = new_ls ? m_ones + 1 : 0;
    m_ls    = new_ls;
    m_phase = (m_k - 1) % DV;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic l, input logic c);
    logic [PW+LW+2:0] got, exp;
    pll_lock  = l;
    clear_cnt = c;
    @(posedge clk);
    model_edge(l, c);
    #1;
    got = {pix_ce, pix_phase, sys_rst, ready, lock_loss_cnt};
    exp = {(m_phase == 0), PW'(m_phase), !m_run, m_run, LW'(m_cnt)};
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL model k=%0d: got ce/ph/rst/rdy/cnt=%h expected %h", m_k, got, exp);
    end
  endtask

  typedef struct {
    int   cycles;
    logic lock;
    logic clr;
    logic exp_rst;
    logic exp_rdy;
    int   exp_phase;
    int   exp_cnt;
  } vec_t;

  vec_t tbl[11];
  logic rl;
  int   len;

  initial begin
    tbl[0]  = '{100, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0};  // idle, no lock
    tbl[1]  = '{10,  1'b1, 1'b0, 1'b1, 1'b0, 4, 0};  // partway through stability count
    tbl[2]  = '{3,   1'b0, 1'b0, 1'b1, 1'b0, 2, 1};  // short drop counted once
    tbl[3]  = '{17,  1'b1, 1'b0, 1'b1, 1'b0, 4, 1};  // fresh count not yet complete
    tbl[4]  = '{5,   1'b1, 1'b0, 1'b1, 1'b0, 4, 1};  // last ARM cycle
    tbl[5]  = '{1,   1'b1, 1'b0, 1'b0, 1'b1, 0, 1};  // first RUN cycle, phase 0
    tbl[6]  = '{1,   1'b0, 1'b0, 1'b0, 1'b1, 1, 1};  // drop on pin, not yet seen
    tbl[7]  = '{1,   1'b0, 1'b0, 1'b0, 1'b1, 2, 2};  // lock_s low, counted
    tbl[8]  = '{1,   1'b0, 1'b0, 1'b1, 1'b0, 3, 2};  // sys_rst back after 3 edges
    tbl[9]  = '{40,  1'b1, 1'b0, 1'b0, 1'b1, 3, 2};  // re-lock and re-release
    tbl[10] = '{1,   1'b1, 1'b1, 1'b0, 1'b1, 4, 0};  // clear alone

    // Asynchronous reset takes effect with no clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst sys_rst",   sys_rst,       1);
    chk("rst ready",     ready,         0);
    chk("rst pix_ce",    pix_ce,        0);
    chk("rst pix_phase", pix_phase,     DV - 1);
    chk("rst cnt",       lock_loss_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Directed table from reset release.
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < tbl[i].cycles; j++) step(tbl[i].lock, tbl[i].clr);
      chk($sformatf("v%0d sys_rst", i), sys_rst,       tbl[i].exp_rst);
      chk($sformatf("v%0d ready", i),   ready,         tbl[i].exp_rdy);
      chk($sformatf("v%0d phase", i),   pix_phase,     tbl[i].exp_phase);
      chk($sformatf("v%0d cnt", i),     lock_loss_cnt, tbl[i].exp_cnt);
    end

    // Saturation after 300 drop/restore pairs.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0); step(1'b0, 1'b0);
      step(1'b1, 1'b0); step(1'b1, 1'b0);
    end
    chk("sat cnt", lock_loss_cnt, 255);
    // Clear coincident with a lock_s fall keeps the event.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("clr+drop cnt", lock_loss_cnt, 1);
    step(1'b0, 1'b0);
    chk("hold cnt", lock_loss_cnt, 1);
    step(1'b0, 1'b1);
    chk("clr cnt", lock_loss_cnt, 0);

    // Reach RUN with a nonzero count, then assert reset between edges on a pix_ce cycle.
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    chk("pre-rst ready", ready, 1);
    chk("pre-rst cnt",   lock_loss_cnt, 1);
    for (int i = 0; i < DV && m_phase != 0; i++) step(1'b1, 1'b0);
    chk("pre-rst pix_ce", pix_ce, 1);
    #2 rst = 1'b1;
    #1;
    chk("async sys_rst",   sys_rst,       1);
    chk("async ready",     ready,         0);
    chk("async pix_ce",    pix_ce,        0);
    chk("async pix_phase", pix_phase,     DV - 1);
    chk("async cnt",       lock_loss_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    chk("relock k20 sys_rst", sys_rst, 1);
    step(1'b1, 1'b0);
    chk("relock k21 sys_rst", sys_rst,   0);
    chk("relock k21 ready",   ready,     1);
    chk("relock k21 pix_ce",  pix_ce,    1);
    chk("relock k21 phase",   pix_phase, 0);

    // Randomised lock behaviour, including toggles faster than the synchroniser.
    rl = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc += len) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(1, 40);
      rl  = ~rl;
      for (int j = 0; j < len; j++) step(rl, ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_seq.md
Name: pll_lock_reset_seq

Overview:
- Sits directly downstream of the 27→126 MHz rPLL wrapper and runs on its 126 MHz output clock.
- Synchronises the PLL lock flag and requires lock to be continuously stable before releasing the system reset.
- Releases reset phase-aligned to a divide-by-DIV pixel clock enable: 25.2 MHz at DIV=5, for the HDMI/VGA pipeline.
- Counts lock-loss events for debug.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before release; must be ≥1.
- DIV, 5: ratio of fast clock to pixel-enable rate; must be ≥2.
- LOSS_W, 8: width of the saturating lock-loss counter.

Ports:
- clk  input  1  126 MHz PLL output clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- pll_lock  input  1  PLL lock; asynchronous to clk.
- clear_cnt  input  1  synchronous clear of lock_loss_cnt.
- pix_ce  output  1  one-cycle pixel enable, high when pix_phase==0.
- pix_phase  output  $clog2(DIV)  fast-clock phase within the pixel period, 0..DIV-1.
- sys_rst  output  1  active-high reset to the downstream pixel domain.
- ready  output  1  high while in RUN.
- lock_loss_cnt  output  LOSS_W  saturating count of lock_s 1→0 transitions.

Behaviour:
- Reset values (asynchronous, take effect immediately, no clock needed):
  - state=WAIT_LOCK, sys_rst=1, ready=0, pix_ce=0.
  - pix_phase=DIV-1, sync flops=0, stability counter=0, lock_loss_cnt=0.
- Synchroniser: two-flop chain on pll_lock → lock_s; 2-cycle latency. No other logic samples pll_lock.
- Phase counter:
  - Free-runs whenever rst=0, independent of state; DIV-1 wraps to 0.
  - First cycle after reset release: pix_phase=0, pix_ce=1.
  - pix_ce is a flop output, high exactly in cycles where pix_phase==0 (every DIV cycles, glitch-free).
- FSM, all transitions on clk:
  - WAIT_LOCK: counter held at 0. lock_s=1 → STABLE.
  - STABLE: counter increments each cycle from 0.
    - lock_s=0 → WAIT_LOCK, counter cleared.
    - counter==LOCK_STABLE_CYCLES-1 with lock_s=1 → ARM. STABLE therefore lasts exactly LOCK_STABLE_CYCLES cycles.
  - ARM: lock_s=0 → WAIT_LOCK. Otherwise, pix_phase==DIV-1 → RUN. ARM lasts 1..DIV cycles.
  - RUN: lock_s=0 → WAIT_LOCK.
- Outputs decoded from the state register:
  - sys_rst = (state != RUN); ready = (state == RUN).
  - sys_rst falls, and ready rises, in the first RUN cycle, which always has pix_phase==0 and pix_ce==1.
- Lock loss in RUN:
  - sys_rst reasserts in the cycle after lock_s is seen low, i.e. ≤3 clk edges after pll_lock falls.
  - The full stability count restarts afterwards.
- lock_loss_cnt:
  - Increments on each lock_s 1→0 transition in any state; saturates at 2^LOSS_W-1.
  - clear_cnt alone → 0.
  - clear_cnt coincident with a transition → 1 (the event is not lost).
- Lock toggling faster than the synchroniser: only transitions visible on lock_s count. No metastability paths bypass the synchroniser.
- Stability counter width: $clog2(LOCK_STABLE_CYCLES)+1; no wrap occurs.

Test Plan (DIV=5, LOCK_STABLE_CYCLES=16, LOSS_W=8):
- Reset released, pll_lock=0 for 100 cycles → sys_rst=1, ready=0; pix_phase cycles 0,1,2,3,4 starting the first cycle after release; pix_ce=1 on every phase 0; lock_loss_cnt=0.
- pll_lock rises and stays high → lock_s high 2 cycles later; after 16 STABLE cycles plus 1..5 ARM cycles, sys_rst falls in a cycle with pix_ce=1 and pix_phase=0; ready rises the same cycle.
- pll_lock low for 3 cycles after 10 STABLE cycles → FSM returns to WAIT_LOCK; lock_loss_cnt=1; after lock returns, a fresh 16-cycle count is required (sys_rst still 1 at cycle 15).
- In RUN, pll_lock falls → sys_rst=1 and ready=0 within 3 clk edges; lock_loss_cnt increments by 1; re-lock repeats the full release sequence.
- 300 lock drop/restore pairs → lock_loss_cnt saturates at 255; clear_cnt pulsed together with a drop → 1; clear_cnt alone → 0.
- rst asserted asynchronously mid-RUN, between clock edges → sys_rst=1, ready=0, pix_ce=0, lock_loss_cnt=0 immediately; after release with pll_lock still high, release occurs only after 2+16+ARM cycles.
